// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request/acknowledge handshake with
// word address, byte enables, write data and returned read data.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  // Pipeline side issues requests and consumes the response.
  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_be,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata
  );

  // Memory side accepts requests and returns the response.
  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_be,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I MEM stage: byte/half/word loads and stores over a variable-latency
// req/ack data-memory port, load extension, MEM/WB register, upstream stall
// while an access is outstanding, and abort after TIMEOUT busy cycles.
module mem_stage #(
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EXE_PCtoReg,
  input  logic [31:0] EXE_ALUout,
  input  logic [31:0] EXE_rs2data,
  input  logic [4:0]  EXE_rdaddr,
  input  logic [2:0]  EXE_Funct3,
  input  logic        EXE_rdsrc,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_RegWrite,
  mem_stage_if.master dm,
  output logic [31:0] MEM_rddata,
  output logic        MEM_stall,
  output logic [31:0] WB_rddata,
  output logic [4:0]  WB_rdaddr,
  output logic        WB_RegWrite,
  output logic        MEM_misalign,
  output logic        MEM_buserr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic        mem_op;
  logic        is_store;
  logic        is_load;
  logic [1:0]  ofs;
  logic [1:0]  size;
  logic        misalign;
  logic        misalign_evt;
  logic        access;

  logic        req_int;
  logic        stall_int;
  logic        abort;

  logic [31:0] ld_shift;
  logic [31:0] ld_val;

  logic [31:0] wb_data_nx;
  logic [4:0]  wb_rd_nx;
  logic        wb_rw_nx;

  // Decode of the access: both MemRead and MemWrite set is handled as a store.
  always_comb begin
    mem_op   = EXE_MemRead | EXE_MemWrite;
    is_store = EXE_MemWrite;
    is_load  = EXE_MemRead & ~EXE_MemWrite;
    ofs      = EXE_ALUout[1:0];
    size     = EXE_Funct3[1:0];
    misalign = mem_op & (((size == 2'b01) & ofs[0]) |
                         (size[1] & (ofs != 2'b00)));
    access   = mem_op & ~misalign;
    misalign_evt = misalign & (state == IDLE);
  end

  // Forwarding value seen by earlier stages.
  always_comb begin
    MEM_rddata = EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout;
  end

  // Memory bus fields derived directly from the frozen EXE inputs.
  always_comb begin
    dm.dm_we   = EXE_MemWrite;
    dm.dm_addr = {EXE_ALUout[31:2], 2'b00};
    dm.dm_be   = '0;
    if (mem_op) begin
      case (size)
        2'b00:   dm.dm_be = 4'b0001 << ofs;
        2'b01:   dm.dm_be = 4'b0011 << ofs;
        default: dm.dm_be = 4'b1111;
      endcase
    end
    case (size)
      2'b00:   dm.dm_wdata = {4{EXE_rs2data[7:0]}};
      2'b01:   dm.dm_wdata = {2{EXE_rs2data[15:0]}};
      default: dm.dm_wdata = EXE_rs2data;
    endcase
  end

  // Load lane extraction; word accesses are aligned so the shift is zero.
  always_comb begin
    ld_shift = dm.dm_rdata >> {ofs, 3'b000};
    case (size)
      2'b00:   ld_val = {{24{ld_shift[7]  & ~EXE_Funct3[2]}}, ld_shift[7:0]};
      2'b01:   ld_val = {{16{ld_shift[15] & ~EXE_Funct3[2]}}, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  // Access FSM: next state, wait counter, request/stall/abort decisions.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_int   = 1'b0;
    stall_int = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          req_int = 1'b1;
          if (!dm.dm_ack) begin
            stall_int = 1'b1;
            state_nx  = BUSY;
            cnt_nx    = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (dm.dm_ack) begin
          req_int  = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          abort    = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          req_int   = 1'b1;
          stall_int = 1'b1;
          cnt_nx    = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Request and stall are masked while reset is held so an abandoned
  // access cannot keep the bus or the pipeline busy.
  always_comb begin
    dm.dm_req = req_int & rst_n;
    MEM_stall = stall_int & rst_n;
  end

  // MEM/WB next value: bubble on stall, abort or misalign; stores never write.
  // Load data is chosen by MemtoReg, qualified by a pure load.
  always_comb begin
    wb_data_nx = '0;
    wb_rd_nx   = '0;
    wb_rw_nx   = 1'b0;
    if (!stall_int && !abort && !misalign_evt) begin
      wb_data_nx = (is_load && EXE_MemtoReg) ? ld_val : MEM_rddata;
      wb_rd_nx   = EXE_rdaddr;
      wb_rw_nx   = EXE_RegWrite & ~is_store;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // MEM/WB pipeline register and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_rddata    <= '0;
      WB_rdaddr    <= '0;
      WB_RegWrite  <= 1'b0;
      MEM_misalign <= 1'b0;
      MEM_buserr   <= 1'b0;
    end else begin
      WB_rddata    <= wb_data_nx;
      WB_rdaddr    <= wb_rd_nx;
      WB_RegWrite  <= wb_rw_nx;
      MEM_misalign <= misalign_evt;
      MEM_buserr   <= abort;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-back and
// bus transactions; a monitor pops and compares as the DUT presents them.
module tb_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] exe_pc, exe_alu, exe_rs2;
  logic [4:0]  exe_rd;
  logic [2:0]  exe_f3;
  logic        exe_src, exe_mr, exe_mw, exe_m2r, exe_rw;
  logic [31:0] mem_rddata, wb_rddata;
  logic        mem_stall, wb_rw, mem_mis, mem_berr;
  logic [4:0]  wb_rdaddr;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .EXE_PCtoReg  (exe_pc),
    .EXE_ALUout   (exe_alu),
    .EXE_rs2data  (exe_rs2),
    .EXE_rdaddr   (exe_rd),
    .EXE_Funct3   (exe_f3),
    .EXE_rdsrc    (exe_src),
    .EXE_MemRead  (exe_mr),
    .EXE_MemWrite (exe_mw),
    .EXE_MemtoReg (exe_m2r),
    .EXE_RegWrite (exe_rw),
    .dm           (bus),
    .MEM_rddata   (mem_rddata),
    .MEM_stall    (mem_stall),
    .WB_rddata    (wb_rddata),
    .WB_rdaddr    (wb_rdaddr),
    .WB_RegWrite  (wb_rw),
    .MEM_misalign (mem_mis),
    .MEM_buserr   (mem_berr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        berr;
    int          stalls;
  } wb_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                         input logic mis, input logic berr, input int st);
    wb_t e;
    e.data = d; e.rd = rd; e.rw = rw; e.mis = mis; e.berr = berr; e.stalls = st;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, input int st);
    bus_t e;
    e.we = we; e.be = be; e.addr = a; e.wdata = wd; e.stalls = st;
    bus_q.push_back(e);
  endtask

  task automatic set_nop();
    exe_pc = '0; exe_alu = '0; exe_rs2 = '0; exe_rd = '0; exe_f3 = '0;
    exe_src = 1'b0; exe_mr = 1'b0; exe_mw = 1'b0; exe_m2r = 1'b0; exe_rw = 1'b0;
  endtask

  task automatic apply(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic src,
                       input logic mr, input logic mw, input logic m2r, input logic rw);
    exe_pc = pc; exe_alu = alu; exe_rs2 = rs2; exe_rd = rd; exe_f3 = f3;
    exe_src = src; exe_mr = mr; exe_mw = mw; exe_m2r = m2r; exe_rw = rw;
  endtask

  // Holds the applied op until a non-stalled edge; ack after ack_after stall cycles (-1: never).
  task automatic wait_done(input int ack_after, input logic [31:0] rdata);
    int  cyc;
    logic st;
    bit  done;
    cyc = 0;
    done = 1'b0;
    bus.dm_rdata = rdata;
    bus.dm_ack = (ack_after == 0);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      st = mem_stall;
      @(posedge clk);
      #1;
      if (!st) begin
        done = 1'b1;
        break;
      end
      cyc++;
      bus.dm_ack = (cyc == ack_after);
    end
    if (!done) fail("op_completion_bound");
    bus.dm_ack = 1'b0;
    bus.dm_rdata = '0;
    set_nop();
  endtask

  // Monitor: pops expected entries on write-back events and bus completions,
  // and checks that every stall cycle leaves a bubble in WB.
  initial begin
    int   run;
    int   last_run;
    logic prev_stall;
    wb_t  e;
    bus_t b;
    run = 0; last_run = 0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; last_run = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_bubble_rw", {31'b0, wb_rw}, 32'd0);
          check("stall_bubble_data", wb_rddata, 32'd0);
        end
        if (wb_rw || mem_mis || mem_berr) begin
          if (wb_q.size() == 0) fail("wb_unexpected");
          else begin
            e = wb_q.pop_front();
            check("wb_rddata", wb_rddata, e.data);
            check("wb_rdaddr", {27'b0, wb_rdaddr}, {27'b0, e.rd});
            check("wb_regwrite", {31'b0, wb_rw}, {31'b0, e.rw});
            check("wb_misalign", {31'b0, mem_mis}, {31'b0, e.mis});
            check("wb_buserr", {31'b0, mem_berr}, {31'b0, e.berr});
            check("wb_stall_cycles", last_run, e.stalls);
          end
        end
        if (bus.dm_req && bus.dm_ack) begin
          if (bus_q.size() == 0) fail("bus_unexpected");
          else begin
            b = bus_q.pop_front();
            check("bus_we", {31'b0, bus.dm_we}, {31'b0, b.we});
            check("bus_be", {28'b0, bus.dm_be}, {28'b0, b.be});
            check("bus_addr", bus.dm_addr, b.addr);
            check("bus_wdata", bus.dm_wdata, b.wdata);
            check("bus_stall_cycles", run, b.stalls);
          end
        end
        if (mem_stall) run++;
        else begin
          last_run = run;
          run = 0;
        end
        prev_stall = mem_stall;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time bound reached");
    $fatal(1, "global timeout");
  end

  initial begin
    set_nop();
    bus.dm_ack = 1'b0;
    bus.dm_rdata = '0;
    #12;
    check("rst_wb_rddata", wb_rddata, 32'd0);
    check("rst_wb_rdaddr", {27'b0, wb_rdaddr}, 32'd0);
    check("rst_wb_rw", {31'b0, wb_rw}, 32'd0);
    check("rst_flags", {30'b0, mem_mis, mem_berr}, 32'd0);
    check("rst_req_stall", {30'b0, bus.dm_req, mem_stall}, 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LB 0x103, zero-wait
    apply(32'h0, 32'h103, 32'h0, 5'd5, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_bus(1'b0, 4'b1000, 32'h100, 32'h0, 0);
    push_wb(32'hFFFF_FF80, 5'd5, 1'b1, 1'b0, 1'b0, 0);
    wait_done(0, 32'h80FF_0000);

    // LHU 0x102, ack after 3 stall cycles
    apply(32'h0, 32'h102, 32'h0, 5'd6, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_bus(1'b0, 4'b1100, 32'h100, 32'h0, 3);
    push_wb(32'h0000_BEEF, 5'd6, 1'b1, 1'b0, 1'b0, 3);
    wait_done(3, 32'hBEEF_1234);

    // SB 0x201
    apply(32'h0, 32'h201, 32'h1234_56AB, 5'd7, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push_bus(1'b1, 4'b0010, 32'h200, 32'hABAB_ABAB, 0);
    wait_done(0, 32'h0);
    check("sb_wb_regwrite", {31'b0, wb_rw}, 32'd0);

    // LW 0x102 misaligned; the ack driven here must be ignored
    apply(32'h0, 32'h102, 32'h0, 5'd8, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_wb(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 0);
    #2;
    check("mis_no_req", {31'b0, bus.dm_req}, 32'd0);
    check("mis_no_stall", {31'b0, mem_stall}, 32'd0);
    wait_done(0, 32'hFFFF_FFFF);

    // LW 0x300, ack never returned
    apply(32'h0, 32'h300, 32'h0, 5'd9, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, TO);
    wait_done(-1, 32'h1234_5678);

    // ALU op proceeds after the abort
    apply(32'h0, 32'h1234, 32'h0, 5'd10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_wb(32'h1234, 5'd10, 1'b1, 1'b0, 1'b0, 0);
    wait_done(0, 32'h0);

    // LH 0x002, one wait cycle
    apply(32'h0, 32'h002, 32'h0, 5'd11, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_bus(1'b0, 4'b1100, 32'h0, 32'h0, 1);
    push_wb(32'hFFFF_8001, 5'd11, 1'b1, 1'b0, 1'b0, 1);
    wait_done(1, 32'h8001_0000);

    // LBU 0x001
    apply(32'h0, 32'h001, 32'h0, 5'd12, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_bus(1'b0, 4'b0010, 32'h0, 32'h0, 0);
    push_wb(32'h0000_009A, 5'd12, 1'b1, 1'b0, 1'b0, 0);
    wait_done(0, 32'h0000_9A00);

    // SH 0x006, two wait cycles
    apply(32'h0, 32'h006, 32'h0000_CAFE, 5'd13, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push_bus(1'b1, 4'b1100, 32'h4, 32'hCAFE_CAFE, 2);
    wait_done(2, 32'h0);

    // SW 0x008
    apply(32'h0, 32'h008, 32'hDEAD_BEEF, 5'd13, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_bus(1'b1, 4'b1111, 32'h8, 32'hDEAD_BEEF, 0);
    wait_done(0, 32'h0);

    // LW 0x010 with ack in the cnt==TIMEOUT cycle: completion wins
    apply(32'h0, 32'h010, 32'h0, 5'd14, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_bus(1'b0, 4'b1111, 32'h10, 32'h0, TO);
    push_wb(32'h55AA_55AA, 5'd14, 1'b1, 1'b0, 1'b0, TO);
    wait_done(TO, 32'h55AA_55AA);

    // jal-style write-back of PCtoReg
    apply(32'h88, 32'h999, 32'h0, 5'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_wb(32'h88, 5'd1, 1'b1, 1'b0, 1'b0, 0);
    wait_done(0, 32'h0);

    // MemRead and MemWrite both set: behaves as a store
    apply(32'h0, 32'h00C, 32'h0102_0304, 5'd15, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    push_bus(1'b1, 4'b1111, 32'hC, 32'h0102_0304, 0);
    wait_done(0, 32'h0);
    check("rw_store_regwrite", {31'b0, wb_rw}, 32'd0);

    // ALU op, then a load abandoned by reset while BUSY
    apply(32'h0, 32'h777, 32'h0, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_wb(32'h777, 5'd3, 1'b1, 1'b0, 1'b0, 0);
    wait_done(0, 32'h0);
    apply(32'h0, 32'h020, 32'h0, 5'd4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_req_before_rst", {31'b0, bus.dm_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'b0, bus.dm_req}, 32'd0);
    check("midrst_stall", {31'b0, mem_stall}, 32'd0);
    check("midrst_wb", {wb_rddata[26:0], wb_rdaddr}, 32'd0);
    check("midrst_wb_rw_flags", {29'b0, wb_rw, mem_mis, mem_berr}, 32'd0);
    set_nop();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply(32'h44, 32'h0, 32'h0, 5'd2, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_wb(32'h44, 5'd2, 1'b1, 1'b0, 1'b0, 0);
    wait_done(0, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("wb_queue_drained", wb_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EXE pipeline register and the WB stage of the five-stage RV32I core. Takes the registered EXE outputs, performs byte/half/word loads and stores against a variable-latency data-memory port with a req/ack handshake, sign- or zero-extends load data, and registers the write-back value into the MEM/WB pipeline register. While an access is outstanding it stalls the upstream pipeline, and it aborts accesses that exceed a timeout.

## Interface
- TIMEOUT, 200: maximum BUSY cycles before an access is aborted (1..2^CNT_W-1)
- CNT_W, 8: wait-counter width
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- EXE_PCtoReg  in  32  PC+4 or PC+imm for jal/jalr/auipc
- EXE_ALUout  in  32  ALU result / memory byte address
- EXE_rs2data  in  32  store data
- EXE_rdaddr  in  5  destination register
- EXE_Funct3  in  3  access size/sign
- EXE_rdsrc, EXE_MemRead, EXE_MemWrite, EXE_MemtoReg, EXE_RegWrite  in  1 each  control from EXE
- dm_ack  in  1  memory completes access this cycle
- dm_rdata  in  32  read word, valid when dm_ack
- dm_req  out  1  access request
- dm_we  out  1  1 = store
- dm_addr  out  32  {EXE_ALUout[31:2],2'b00}
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- MEM_rddata  out  32  forwarding value: EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout (combinational)
- MEM_stall  out  1  freeze IF/ID/EXE registers
- WB_rddata  out  32  registered write-back data
- WB_rdaddr  out  5  registered destination
- WB_RegWrite  out  1  registered write enable
- MEM_misalign  out  1  registered one-cycle pulse: misaligned access dropped
- MEM_buserr  out  1  registered one-cycle pulse: access timed out

## Operation
- Memory op = EXE_MemRead | EXE_MemWrite (both set: treat as store).
- Size from Funct3[1:0]: 00 byte, 01 half, 10/11 word; Funct3[2] = unsigned for loads.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. No request issued; WB gets bubble (RegWrite=0); MEM_misalign pulses next cycle; no stall.
- dm_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Driven for loads and stores.
- dm_wdata: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- Load data: shift dm_rdata right by 8*addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU); word unchanged.
- WB value: load → extracted data; else MEM_rddata. Store: WB_RegWrite forced 0.
- FSM IDLE/BUSY, counter cnt:
  - IDLE, aligned memory op: dm_req=1. dm_ack → complete, MEM_stall=0. No ack → MEM_stall=1, go BUSY, cnt=1.
  - BUSY: dm_req=1, outputs held stable (inputs are frozen by stall). dm_ack → complete, MEM_stall=0, go IDLE. No ack and cnt==TIMEOUT → abort: dm_req=0 this cycle, MEM_stall=0, WB bubble, MEM_buserr pulses, go IDLE. Otherwise cnt+1, MEM_stall=1.
- Non-memory op: no request, WB register loads directly, no stall.
- Every stall cycle loads a bubble (RegWrite=0, rdaddr=0, data=0) into WB.

## Timing
- Reset (rst_n low, async): state IDLE, cnt 0, WB_rddata/WB_rdaddr/WB_RegWrite 0, MEM_misalign/MEM_buserr 0. dm_req/dm_we/dm_be/dm_wdata/dm_addr/MEM_stall/MEM_rddata are combinational from state and inputs and read 0 while inputs are 0. Reset mid-BUSY abandons the access; no write-back.
- Zero-wait memory (ack in request cycle): 1-cycle stage latency, no stall.
- N-cycle memory: MEM_stall high exactly N cycles; WB updates on the edge ending the ack cycle.
- dm_ack while dm_req=0 is ignored.
- ack arriving in the cycle cnt==TIMEOUT: completion wins, no buserr.
- MEM_misalign/MEM_buserr: high exactly one cycle after the event edge.

## Test plan
- LB addr 0x103, dm_rdata 0x80FF_0000, ack same cycle → dm_be 4'b1000, WB_rddata 0xFFFF_FF80, WB_RegWrite 1, no stall.
- LHU addr 0x102, ack after 3 cycles, dm_rdata 0xBEEF_1234 → MEM_stall high 3 cycles, WB bubbles during the stall, then WB_rddata 0x0000_BEEF.
- SB addr 0x201, rs2 0x1234_56AB → dm_we 1, dm_be 4'b0010, dm_wdata 0xABAB_ABAB, WB_RegWrite 0.
- LW addr 0x102 → dm_req never asserted, MEM_misalign pulses once, WB_RegWrite 0, MEM_stall 0.
- Load with ack never returned, TIMEOUT=4 → stall 4 cycles, dm_req drops, MEM_buserr one-cycle pulse, FSM returns to IDLE, next instruction proceeds.
- rst_n asserted during BUSY → WB outputs and flags 0 immediately, dm_req 0; after release, a non-memory op with rdsrc=1, PCtoReg 0x44 → WB_rddata 0x44.
